lsu_split: RTL and testbench
============================

# lsu_split

Parametrised load/store unit sitting between the core's execute stage and the data RAM port. It replaces the single-cycle combinational load/store path with a multicycle engine that has a request/acknowledge memory handshake. Accesses that straddle a word boundary are completed as two word accesses and merged, or rejected with an error. Data width is selectable (32 or 64 bit).

## Interface
- `ADDR_WIDTH`, 31: MSB index of byte and word address buses.
- `DATA_WIDTH`, 31: MSB index of data buses; legal values 31 and 63. NB = (DATA_WIDTH+1)/8 bytes per word; OFS = log2(NB).
- `ALLOW_MISALIGNED`, 1: 1 = split straddling accesses; 0 = flag them as errors.

Ports (clock and reset first):
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clk_en` in 1: when low, all state holds and `i_mem_ack` is ignored.
- `i_valid` in 1: access request.
- `o_ready` out 1: request accepted when `i_valid & o_ready` at a clock edge.
- `i_we` in 1: 1 = store, 0 = load.
- `i_funct3` in 3: RISC-V size/sign code.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011 LD and 110 LWU only when NB=8.
  - Stores: 000, 001, 010; 011 only when NB=8.
- `i_addr` in ADDR_WIDTH+1: byte address.
- `i_wdata` in DATA_WIDTH+1: store data, right-aligned.
- `o_done` out 1: one-cycle completion pulse.
- `o_err` out 1: valid with `o_done`; illegal funct3, or misaligned access when ALLOW_MISALIGNED=0.
- `o_rdata` out DATA_WIDTH+1: extended load result; valid with `o_done`; 0 for stores and errors.
- `o_mem_req` out 1: memory access request, held until acknowledged.
- `o_mem_we` out 1: write strobe for the current access.
- `o_mem_be` out NB: byte enables; driven for reads too.
- `o_mem_addr` out ADDR_WIDTH+1: word address = byte address >> OFS.
- `o_mem_wdata` out DATA_WIDTH+1: lane-positioned store data.
- `i_mem_ack` in 1: access complete; `i_mem_rdata` is valid in this cycle.
- `i_mem_rdata` in DATA_WIDTH+1: read word.

## Operation
- States:
  - IDLE: `o_ready`=1 only here.
  - ACC0: first word.
  - ACC1: second word.
  - RESP: `o_done`=1.
- On accept, register the request and compute:
  - size S ∈ {1,2,4,8} bytes;
  - off = addr[OFS-1:0];
  - split = off+S > NB.
- Transitions from IDLE:
  - Illegal funct3 → RESP with err=1.
  - split & !ALLOW_MISALIGNED → RESP with err=1.
  - Otherwise → ACC0.
- Erroring requests never assert `o_mem_req`.
- Byte enables, with mask = (1<<S)-1:
  - ACC0: `o_mem_be` = (mask<<off)[NB-1:0].
  - ACC1: `o_mem_be` = mask>>(NB-off).
- Write data: `i_wdata` shifted left by off*8 within a 2·NB-byte lane. Low word goes out in ACC0, high word in ACC1.
- Addresses:
  - ACC1 address = ACC0 address + 1, wrapping modulo 2^(ADDR_WIDTH+1-OFS).
  - The top OFS bits of `o_mem_addr` are 0.
- Sequencing:
  - ACC0 with ack: latch rdata low, then go to ACC1 if split, else RESP.
  - ACC1 with ack: latch rdata high, then go to RESP.
- Load result: {high, low} >> off*8, truncated to S bytes, then extended. Sign-extend for LB/LH/LW(NB=8); zero-extend for LBU/LHU/LWU; LD is not extended.
- RESP → IDLE unconditionally (when `clk_en`=1).

## Timing
- Reset (async): state IDLE; `o_ready`=1; every other output 0 (`o_done`, `o_err`, `o_rdata`, `o_mem_req`, `o_mem_we`, `o_mem_be`, `o_mem_addr`, `o_mem_wdata`).
- All outputs are registered or decoded from state only. There is no combinational path from `i_*` to `o_*`.
- Latency, with accept at edge 0 and zero-wait memory:
  - Aligned: `o_mem_req` in cycle 1, `o_done` in cycle 2.
  - Split: second request in cycle 2, `o_done` in cycle 3.
  - Error: `o_done` in cycle 1.
  - Each wait state adds one cycle.
- Memory side:
  - `o_mem_req`/addr/be/we/wdata stay stable while unacknowledged.
  - `o_mem_req` drops for at least zero cycles between ACC0 and ACC1. It may stay high, but addr/be change on the ACC0 ack edge.
- `i_valid` during a busy state is ignored (`o_ready`=0). The requester must hold the request until accepted.
- `clk_en`=0: state, outputs and captured data freeze. An ack arriving then is not sampled.
- `rst_n` asserted mid-access (any state) aborts immediately. No `o_done` is produced and no further memory requests are issued.
- Back-to-back: a new request is accepted in the cycle after RESP.

## Test plan
- Aligned LW, i_addr=0x100, mem word 0x40=0xDEADBEEF, ack in the same cycle → `o_mem_addr`=0x40, be=1111, `o_rdata`=0xDEADBEEF, `o_done` 2 cycles after accept.
- Split LW, i_addr=0x103, word 0x40=0x44332211, word 0x41=0x88776655 → two requests: 0x40 with be=1000, then 0x41 with be=0111. `o_rdata`=0x77665544 with `o_done` at cycle 3.
- Split SH, i_addr=0x0FF, i_wdata=0x0000ABCD:
  - first write: 0x3F, be=1000, wdata=0xCD000000;
  - second write: 0x40, be=0001, wdata=0x000000AB;
  - `o_err`=0.
- Sign handling at i_addr=0x102 with word 0x00800000: LB → 0xFFFFFF80; LBU → 0x00000080. Add 3 wait states → `o_done` at cycle 5 and request signals stable throughout.
- ALLOW_MISALIGNED=0, LW at 0x102 → `o_done`=1 and `o_err`=1 one cycle after accept, `o_rdata`=0, `o_mem_req` never high. funct3=011 with NB=4 → same response.
- `rst_n` pulsed low in ACC1 of a split load → outputs return to reset values at once, with no `o_done`. `clk_en` held low 4 cycles in ACC0 while acks are present → no state change; completion resumes after `clk_en` returns high.

Source files
------------

// File: rtl/lsu_split.sv
// Multicycle load/store engine between execute and a req/ack data RAM port.
// Word-straddling accesses are issued as two word accesses and merged, or rejected.
module lsu_split #(
    parameter int ADDR_WIDTH       = 31,
    parameter int DATA_WIDTH       = 31,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clk_en,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic                            i_we,
    input  logic [2:0]                      i_funct3,
    input  logic [ADDR_WIDTH:0]             i_addr,
    input  logic [DATA_WIDTH:0]             i_wdata,
    output logic                            o_done,
    output logic                            o_err,
    output logic [DATA_WIDTH:0]             o_rdata,
    output logic                            o_mem_req,
    output logic                            o_mem_we,
    output logic [(DATA_WIDTH+1)/8-1:0]     o_mem_be,
    output logic [ADDR_WIDTH:0]             o_mem_addr,
    output logic [DATA_WIDTH:0]             o_mem_wdata,
    input  logic                            i_mem_ack,
    input  logic [DATA_WIDTH:0]             i_mem_rdata,
    output logic [1:0]                      dbg_state
);

    localparam int DW  = DATA_WIDTH + 1;
    localparam int AW  = ADDR_WIDTH + 1;
    localparam int NB  = DW / 8;
    localparam int OFS = $clog2(NB);
    localparam int WAW = AW - OFS;
    localparam logic [2*NB-1:0] ONE_L = 1;
    localparam logic [WAW-1:0]  ONE_W = 1;

    // Handshakes: a request is taken on a clk_en edge where i_valid & o_ready;
    // o_mem_req holds addr/be/we/wdata stable until i_mem_ack is sampled on a clk_en edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]        req_size;
    logic              req_sext;
    logic              req_legal;
    logic [OFS-1:0]    req_off;
    logic              req_split;
    logic              req_fail;
    logic [2*NB-1:0]   lane_mask;
    logic [2*DW-1:0]   lane_wdata;
    logic [WAW-1:0]    word_lo;
    logic [WAW-1:0]    word_hi;

    logic [OFS-1:0]    off_q;
    logic [3:0]        size_q;
    logic              sext_q;
    logic              split_q;
    logic [NB-1:0]     be_hi_q;
    logic [DW-1:0]     wdata_hi_q;
    logic [AW-1:0]     addr_hi_q;
    logic [DW-1:0]     rdata_lo_q;

    always_comb begin
        req_size  = 4'd0;
        req_sext  = 1'b0;
        req_legal = 1'b0;
        if (i_we) begin
            case (i_funct3)
                3'b000:  begin req_size = 4'd1; req_legal = 1'b1; end
                3'b001:  begin req_size = 4'd2; req_legal = 1'b1; end
                3'b010:  begin req_size = 4'd4; req_legal = 1'b1; end
                3'b011:  begin req_size = 4'd8; req_legal = (NB == 8); end
                default: ;
            endcase
        end else begin
            case (i_funct3)
                3'b000:  begin req_size = 4'd1; req_legal = 1'b1; req_sext = 1'b1; end
                3'b001:  begin req_size = 4'd2; req_legal = 1'b1; req_sext = 1'b1; end
                3'b010:  begin req_size = 4'd4; req_legal = 1'b1; req_sext = (NB == 8); end
                3'b011:  begin req_size = 4'd8; req_legal = (NB == 8); end
                3'b100:  begin req_size = 4'd1; req_legal = 1'b1; end
                3'b101:  begin req_size = 4'd2; req_legal = 1'b1; end
                3'b110:  begin req_size = 4'd4; req_legal = (NB == 8); end
                default: ;
            endcase
        end
    end

    // Everything is positioned in a two-word lane; the low half feeds ACC0, the high half ACC1.
    assign req_off    = i_addr[OFS-1:0];
    assign req_split  = (int'(req_off) + int'(req_size)) > NB;
    assign req_fail   = !req_legal || (req_split && !ALLOW_MISALIGNED);
    assign lane_mask  = ((ONE_L << req_size) - ONE_L) << req_off;
    assign lane_wdata = {{DW{1'b0}}, i_wdata} << {req_off, 3'b000};
    assign word_lo    = i_addr[AW-1:OFS];
    assign word_hi    = word_lo + ONE_W;

    function automatic logic [DW-1:0] extend_load(input logic [2*DW-1:0] lane);
        logic [DW-1:0] base;
        logic [DW-1:0] res;
        logic          fill;
        int            nbits;
        base  = DW'(lane >> {off_q, 3'b000});
        nbits = 8 * int'(size_q);
        fill  = 1'b0;
        res   = '0;
        for (int i = 0; i < DW; i++) begin
            if (i == nbits - 1) fill = base[i] & sext_q;
        end
        for (int i = 0; i < DW; i++) res[i] = (i < nbits) ? base[i] : fill;
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else if (clk_en) state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (i_valid) state_next = req_fail ? S_RESP : S_ACC0;
            S_ACC0: if (i_mem_ack) state_next = split_q ? S_ACC1 : S_RESP;
            S_ACC1: if (i_mem_ack) state_next = S_RESP;
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready   = (state == S_IDLE);
        o_done    = (state == S_RESP);
        o_mem_req = (state == S_ACC0) || (state == S_ACC1);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_err       <= 1'b0;
            o_rdata     <= '0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            off_q       <= '0;
            size_q      <= '0;
            sext_q      <= 1'b0;
            split_q     <= 1'b0;
            be_hi_q     <= '0;
            wdata_hi_q  <= '0;
            addr_hi_q   <= '0;
            rdata_lo_q  <= '0;
        end else if (clk_en) begin
            case (state)
                S_IDLE: if (i_valid) begin
                    off_q      <= req_off;
                    size_q     <= req_size;
                    sext_q     <= req_sext;
                    split_q    <= req_split;
                    be_hi_q    <= lane_mask[2*NB-1:NB];
                    wdata_hi_q <= lane_wdata[2*DW-1:DW];
                    addr_hi_q  <= {{OFS{1'b0}}, word_hi};
                    if (req_fail) begin
                        o_err   <= 1'b1;
                        o_rdata <= '0;
                    end else begin
                        o_mem_we    <= i_we;
                        o_mem_be    <= lane_mask[NB-1:0];
                        o_mem_addr  <= {{OFS{1'b0}}, word_lo};
                        o_mem_wdata <= lane_wdata[DW-1:0];
                    end
                end
                S_ACC0: if (i_mem_ack) begin
                    rdata_lo_q <= i_mem_rdata;
                    if (split_q) begin
                        o_mem_be    <= be_hi_q;
                        o_mem_addr  <= addr_hi_q;
                        o_mem_wdata <= wdata_hi_q;
                    end else begin
                        o_rdata     <= o_mem_we ? '0 : extend_load({{DW{1'b0}}, i_mem_rdata});
                        o_mem_we    <= 1'b0;
                        o_mem_be    <= '0;
                        o_mem_addr  <= '0;
                        o_mem_wdata <= '0;
                    end
                end
                S_ACC1: if (i_mem_ack) begin
                    o_rdata     <= o_mem_we ? '0 : extend_load({i_mem_rdata, rdata_lo_q});
                    o_mem_we    <= 1'b0;
                    o_mem_be    <= '0;
                    o_mem_addr  <= '0;
                    o_mem_wdata <= '0;
                end
                S_RESP: begin
                    o_err   <= 1'b0;
                    o_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_split.sv
// Bench for lsu_split: directed scenarios plus randomized accesses against a byte-level model.
module tb_lsu_split;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        i_valid;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    logic        a_ready, a_done, a_err, a_mem_req, a_mem_we;
    logic [31:0] a_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_be;
    logic [1:0]  a_dbg;
    logic        b_ready, b_done, b_err, b_mem_req, b_mem_we;
    logic [31:0] b_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_be;
    logic [1:0]  b_dbg;

    logic        sel;
    logic        m_done, m_err, m_mem_req, m_mem_we;
    logic [31:0] m_rdata, m_mem_addr, m_mem_wdata;
    logic [3:0]  m_mem_be;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_w [logic [31:0]];
    logic [31:0] exp_q [$];

    int          obs_nreq, obs_done_cyc;
    logic [31:0] obs_addr [2];
    logic [31:0] obs_wdata [2];
    logic [3:0]  obs_be [2];
    logic        obs_we [2];
    logic [31:0] obs_rdata;
    logic        obs_err, obs_stable;

    lsu_split #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .ALLOW_MISALIGNED(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_valid(i_valid), .o_ready(a_ready),
        .i_we(i_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_done(a_done), .o_err(a_err), .o_rdata(a_rdata), .o_mem_req(a_mem_req),
        .o_mem_we(a_mem_we), .o_mem_be(a_mem_be), .o_mem_addr(a_mem_addr),
        .o_mem_wdata(a_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .dbg_state(a_dbg)
    );

    lsu_split #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .ALLOW_MISALIGNED(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_valid(i_valid), .o_ready(b_ready),
        .i_we(i_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_done(b_done), .o_err(b_err), .o_rdata(b_rdata), .o_mem_req(b_mem_req),
        .o_mem_we(b_mem_we), .o_mem_be(b_mem_be), .o_mem_addr(b_mem_addr),
        .o_mem_wdata(b_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .dbg_state(b_dbg)
    );

    assign m_done      = sel ? b_done      : a_done;
    assign m_err       = sel ? b_err       : a_err;
    assign m_rdata     = sel ? b_rdata     : a_rdata;
    assign m_mem_req   = sel ? b_mem_req   : a_mem_req;
    assign m_mem_we    = sel ? b_mem_we    : a_mem_we;
    assign m_mem_be    = sel ? b_mem_be    : a_mem_be;
    assign m_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
    assign m_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [31:0] wa);
        if (mem_w.exists(wa)) return mem_w[wa];
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Byte-level reference: expected requests go to exp_q as (addr, be, we, wdata).
    task automatic model_access(input logic allow, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                                output logic exp_err, output logic [31:0] exp_rdata,
                                output int exp_nreq, output int exp_done);
        int s, off, j;
        logic sx, legal;
        logic [31:0] val, wa, wd, ba, w;
        logic [3:0] be;
        s = 0; sx = 1'b0; legal = 1'b1;
        if (we) begin
            case (f3)
                3'd0: s = 1;
                3'd1: s = 2;
                3'd2: s = 4;
                default: legal = 1'b0;
            endcase
        end else begin
            case (f3)
                3'd0: begin s = 1; sx = 1'b1; end
                3'd1: begin s = 2; sx = 1'b1; end
                3'd2: s = 4;
                3'd4: s = 1;
                3'd5: s = 2;
                default: legal = 1'b0;
            endcase
        end
        off = int'(addr[1:0]);
        if (!legal || (!allow && off + s > 4)) begin
            exp_err = 1'b1; exp_rdata = '0; exp_nreq = 0; exp_done = 1;
            return;
        end
        exp_err  = 1'b0;
        exp_nreq = (off + s > 4) ? 2 : 1;
        for (int k = 0; k < exp_nreq; k++) begin
            wa = ((addr >> 2) + 32'(k)) & 32'h3FFF_FFFF;
            be = '0; wd = '0;
            for (int b = 0; b < 4; b++) begin
                j = k * 4 + b - off;
                if (j >= 0 && j < s) be[b] = 1'b1;
                if (j >= 0 && j < 4) wd[8*b +: 8] = wdata[8*j +: 8];
            end
            exp_q.push_back(wa);
            exp_q.push_back({28'd0, be});
            exp_q.push_back({31'd0, we});
            exp_q.push_back(wd);
        end
        val = '0;
        for (int i = 0; i < s; i++) begin
            ba = addr + 32'(i);
            w  = rd_word(ba >> 2);
            val[8*i +: 8] = w[8*int'(ba[1:0]) +: 8];
        end
        if (sx && val[8*s-1]) for (int i = 8 * s; i < 32; i++) val[i] = 1'b1;
        exp_rdata = we ? '0 : val;
        exp_done  = 1 + exp_nreq * (waits + 1);
    endtask

    // Drives one request and plays memory with a fixed number of wait states per access.
    task automatic run_access(input logic s, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata, input int waits);
        int wc;
        bit got;
        logic [31:0] w;
        sel = s; obs_nreq = 0; obs_stable = 1'b1; got = 0; wc = 0;
        obs_done_cyc = 0; obs_rdata = '0; obs_err = 1'b0;
        @(negedge clk);
        i_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            @(negedge clk);
            i_valid = 1'b0; i_mem_ack = 1'b0;
            if (m_done) begin
                got = 1; obs_done_cyc = cyc; obs_rdata = m_rdata; obs_err = m_err;
            end else if (m_mem_req) begin
                if (wc == 0) begin
                    if (obs_nreq < 2) begin
                        obs_addr[obs_nreq] = m_mem_addr; obs_be[obs_nreq] = m_mem_be;
                        obs_we[obs_nreq] = m_mem_we; obs_wdata[obs_nreq] = m_mem_wdata;
                    end
                    obs_nreq++;
                end else if (obs_nreq <= 2 && (m_mem_addr !== obs_addr[obs_nreq-1] ||
                         m_mem_be !== obs_be[obs_nreq-1] || m_mem_we !== obs_we[obs_nreq-1] ||
                         m_mem_wdata !== obs_wdata[obs_nreq-1])) begin
                    obs_stable = 1'b0;
                end
                if (wc == waits) begin
                    i_mem_ack = 1'b1;
                    w = rd_word(m_mem_addr);
                    i_mem_rdata = w;
                    if (m_mem_we) begin
                        for (int b = 0; b < 4; b++) if (m_mem_be[b]) w[8*b +: 8] = m_mem_wdata[8*b +: 8];
                        mem_w[m_mem_addr] = w;
                    end
                    wc = 0;
                end else begin
                    wc++;
                end
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout: got no o_done within 40 cycles, required o_done (addr=%h)", addr);
        end
        for (int k = 0; k < 20 && !(a_ready && b_ready); k++) begin
            @(negedge clk);
            i_mem_ack = a_mem_req | b_mem_req;
            i_mem_rdata = '0;
        end
        i_mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({a_ready, a_done, a_err, a_rdata, a_mem_req, a_mem_we, a_mem_be, a_mem_addr, a_mem_wdata} !==
            {1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b done=%b err=%b rdata=%h req=%b we=%b be=%b addr=%h wdata=%h, required ready=1 rest 0",
                     a_ready, a_done, a_err, a_rdata, a_mem_req, a_mem_we, a_mem_be, a_mem_addr, a_mem_wdata);
        end
        checks++;
        if (b_ready !== 1'b1 || b_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: ready=%b req=%b, required 1 0", b_ready, b_mem_req);
        end
    endtask

    task automatic test_aligned;
        mem_w[32'h40] = 32'hDEAD_BEEF;
        run_access(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 0);
        checks++;
        if (obs_nreq !== 1 || obs_addr[0] !== 32'h40 || obs_be[0] !== 4'b1111 || obs_we[0] !== 1'b0) begin
            failures++;
            $display("FAIL aligned_req: n=%0d addr=%h be=%b we=%b, required 1 00000040 1111 0",
                     obs_nreq, obs_addr[0], obs_be[0], obs_we[0]);
        end
        checks++;
        if (obs_rdata !== 32'hDEAD_BEEF || obs_err !== 1'b0 || obs_done_cyc !== 2) begin
            failures++;
            $display("FAIL aligned_resp: rdata=%h err=%b done_cyc=%0d, required deadbeef 0 2",
                     obs_rdata, obs_err, obs_done_cyc);
        end
    endtask

    task automatic test_split_load;
        mem_w[32'h40] = 32'h4433_2211;
        mem_w[32'h41] = 32'h8877_6655;
        run_access(1'b0, 1'b0, 3'b010, 32'h103, 32'h0, 0);
        checks++;
        if (obs_nreq !== 2 || obs_addr[0] !== 32'h40 || obs_be[0] !== 4'b1000 ||
            obs_addr[1] !== 32'h41 || obs_be[1] !== 4'b0111) begin
            failures++;
            $display("FAIL split_load_req: n=%0d %h/%b %h/%b, required 2 00000040/1000 00000041/0111",
                     obs_nreq, obs_addr[0], obs_be[0], obs_addr[1], obs_be[1]);
        end
        checks++;
        if (obs_rdata !== 32'h7766_5544 || obs_done_cyc !== 3 || obs_err !== 1'b0) begin
            failures++;
            $display("FAIL split_load_resp: rdata=%h done_cyc=%0d err=%b, required 77665544 3 0",
                     obs_rdata, obs_done_cyc, obs_err);
        end
    endtask

    task automatic test_split_store;
        run_access(1'b0, 1'b1, 3'b001, 32'h0FF, 32'h0000_ABCD, 0);
        checks++;
        if (obs_nreq !== 2 || obs_addr[0] !== 32'h3F || obs_be[0] !== 4'b1000 ||
            obs_wdata[0] !== 32'hCD00_0000 || obs_we[0] !== 1'b1) begin
            failures++;
            $display("FAIL split_store_w0: n=%0d addr=%h be=%b wdata=%h we=%b, required 2 0000003f 1000 cd000000 1",
                     obs_nreq, obs_addr[0], obs_be[0], obs_wdata[0], obs_we[0]);
        end
        checks++;
        if (obs_addr[1] !== 32'h40 || obs_be[1] !== 4'b0001 || obs_wdata[1] !== 32'h0000_00AB ||
            obs_we[1] !== 1'b1 || obs_err !== 1'b0 || obs_rdata !== 32'd0) begin
            failures++;
            $display("FAIL split_store_w1: addr=%h be=%b wdata=%h we=%b err=%b rdata=%h, required 00000040 0001 000000ab 1 0 0",
                     obs_addr[1], obs_be[1], obs_wdata[1], obs_we[1], obs_err, obs_rdata);
        end
    endtask

    task automatic test_sign;
        mem_w[32'h40] = 32'h0080_0000;
        run_access(1'b0, 1'b0, 3'b000, 32'h102, 32'h0, 0);
        checks++;
        if (obs_rdata !== 32'hFFFF_FF80 || obs_be[0] !== 4'b0100) begin
            failures++;
            $display("FAIL sign_lb: rdata=%h be=%b, required ffffff80 0100", obs_rdata, obs_be[0]);
        end
        run_access(1'b0, 1'b0, 3'b100, 32'h102, 32'h0, 3);
        checks++;
        if (obs_rdata !== 32'h0000_0080 || obs_done_cyc !== 5 || obs_stable !== 1'b1) begin
            failures++;
            $display("FAIL sign_lbu_wait: rdata=%h done_cyc=%0d stable=%b, required 00000080 5 1",
                     obs_rdata, obs_done_cyc, obs_stable);
        end
    endtask

    task automatic test_errors;
        run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0);
        checks++;
        if (obs_done_cyc !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'd0 || obs_nreq !== 0) begin
            failures++;
            $display("FAIL err_misaligned: done_cyc=%0d err=%b rdata=%h nreq=%0d, required 1 1 0 0",
                     obs_done_cyc, obs_err, obs_rdata, obs_nreq);
        end
        run_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0);
        checks++;
        if (obs_done_cyc !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'd0 || obs_nreq !== 0) begin
            failures++;
            $display("FAIL err_ld_nb4: done_cyc=%0d err=%b rdata=%h nreq=%0d, required 1 1 0 0",
                     obs_done_cyc, obs_err, obs_rdata, obs_nreq);
        end
        run_access(1'b0, 1'b1, 3'b100, 32'h104, 32'h1234, 0);
        checks++;
        if (obs_done_cyc !== 1 || obs_err !== 1'b1 || obs_nreq !== 0) begin
            failures++;
            $display("FAIL err_store_f3: done_cyc=%0d err=%b nreq=%0d, required 1 1 0",
                     obs_done_cyc, obs_err, obs_nreq);
        end
    endtask

    task automatic test_clk_en;
        logic frozen;
        logic [1:0] sa, sb;
        mem_w[32'h80] = 32'hCAFE_F00D;
        sel = 1'b0;
        @(negedge clk);
        i_valid = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h200;
        @(negedge clk);
        i_valid = 1'b0;
        sa = a_dbg; sb = b_dbg;
        clk_en = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h1111_2222;
        frozen = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (a_mem_req !== 1'b1 || a_done !== 1'b0 || a_mem_addr !== 32'h80 || a_mem_be !== 4'hF ||
                a_dbg !== sa || b_dbg !== sb) frozen = 1'b0;
        end
        checks++;
        if (frozen !== 1'b1) begin
            failures++;
            $display("FAIL clk_en_freeze: req=%b done=%b addr=%h be=%b, required held 1 0 00000080 1111",
                     a_mem_req, a_done, a_mem_addr, a_mem_be);
        end
        clk_en = 1'b1; i_mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        i_mem_ack = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_rdata !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL clk_en_resume: done=%b rdata=%h, required 1 cafef00d", a_done, a_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        mem_w[32'h40] = 32'h0102_0304;
        mem_w[32'h81] = 32'hA5A5_0F0F;
        sel = 1'b0;
        @(negedge clk);
        i_valid = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h100;
        @(negedge clk);
        i_addr = 32'h204; i_mem_ack = 1'b1; i_mem_rdata = 32'h0102_0304;
        @(negedge clk);
        i_mem_ack = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_rdata !== 32'h0102_0304 || a_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: done=%b rdata=%h ready=%b, required 1 01020304 0", a_done, a_rdata, a_ready);
        end
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: ready=%b, required 1", a_ready);
        end
        @(negedge clk);
        i_valid = 1'b0;
        checks++;
        if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h81) begin
            failures++;
            $display("FAIL b2b_second_req: req=%b addr=%h, required 1 00000081", a_mem_req, a_mem_addr);
        end
        i_mem_ack = 1'b1; i_mem_rdata = 32'hA5A5_0F0F;
        @(negedge clk);
        i_mem_ack = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_rdata !== 32'hA5A5_0F0F) begin
            failures++;
            $display("FAIL b2b_second_resp: done=%b rdata=%h, required 1 a5a50f0f", a_done, a_rdata);
        end
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || a_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL b2b_single_accept: ready=%b req=%b, required 1 0", a_ready, a_mem_req);
        end
    endtask

    task automatic test_random;
        logic s, we, e_err;
        logic [2:0] f3;
        logic [31:0] addr, wdata, e_rdata, base_w, e;
        int waits, e_nreq, e_done;
        for (int n = 0; n < 80; n++) begin
            s  = ($urandom_range(0, 3) == 0);
            we = $urandom_range(0, 1) == 1;
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0: base_w = 32'h3FFF_FFFF;
                    1: base_w = 32'h3F;
                    2: base_w = 32'h40;
                    default: base_w = 32'($urandom_range(0, 255));
                endcase
                addr = (base_w << 2) | 32'($urandom_range(0, 3));
            end else begin
                addr = $urandom;
            end
            wdata = $urandom;
            waits = $urandom_range(0, 2);
            model_access(!s, we, f3, addr, wdata, waits, e_err, e_rdata, e_nreq, e_done);
            run_access(s, we, f3, addr, wdata, waits);
            checks++;
            if (obs_err !== e_err || obs_rdata !== e_rdata || obs_done_cyc !== e_done || obs_nreq !== e_nreq) begin
                failures++;
                $display("FAIL rand_resp[%0d]: err=%b rdata=%h done_cyc=%0d nreq=%0d, required %b %h %0d %0d (addr=%h f3=%0d we=%b)",
                         n, obs_err, obs_rdata, obs_done_cyc, obs_nreq, e_err, e_rdata, e_done, e_nreq, addr, f3, we);
            end
            checks++;
            if (obs_stable !== 1'b1) begin
                failures++;
                $display("FAIL rand_stable[%0d]: request changed while waiting, required stable", n);
            end
            for (int k = 0; k < e_nreq; k++) begin
                e = exp_q.pop_front();
                if (k < obs_nreq && k < 2) begin
                    checks++;
                    if (obs_addr[k] !== e) begin
                        failures++;
                        $display("FAIL rand_addr[%0d.%0d]: %h, required %h", n, k, obs_addr[k], e);
                    end
                end
                e = exp_q.pop_front();
                if (k < obs_nreq && k < 2) begin
                    checks++;
                    if ({28'd0, obs_be[k]} !== e) begin
                        failures++;
                        $display("FAIL rand_be[%0d.%0d]: %b, required %b", n, k, obs_be[k], e[3:0]);
                    end
                end
                e = exp_q.pop_front();
                if (k < obs_nreq && k < 2) begin
                    checks++;
                    if ({31'd0, obs_we[k]} !== e) begin
                        failures++;
                        $display("FAIL rand_we[%0d.%0d]: %b, required %b", n, k, obs_we[k], e[0]);
                    end
                end
                e = exp_q.pop_front();
                if (k < obs_nreq && k < 2) begin
                    checks++;
                    if (obs_wdata[k] !== e) begin
                        failures++;
                        $display("FAIL rand_wdata[%0d.%0d]: %h, required %h", n, k, obs_wdata[k], e);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_access;
        logic seen;
        mem_w[32'h40] = 32'h4433_2211;
        mem_w[32'h41] = 32'h8877_6655;
        sel = 1'b0;
        @(negedge clk);
        i_valid = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h103;
        @(negedge clk);
        i_valid = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h4433_2211;
        @(negedge clk);
        checks++;
        if (a_mem_req !== 1'b1 || a_mem_addr !== 32'h41) begin
            failures++;
            $display("FAIL rst_reach_acc1: req=%b addr=%h, required 1 00000041", a_mem_req, a_mem_addr);
        end
        i_mem_rdata = 32'h8877_6655;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_ready, a_done, a_err, a_rdata, a_mem_req, a_mem_we, a_mem_be, a_mem_addr, a_mem_wdata} !==
            {1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL rst_mid_outputs: ready=%b done=%b err=%b rdata=%h req=%b we=%b be=%b addr=%h wdata=%h, required ready=1 rest 0",
                     a_ready, a_done, a_err, a_rdata, a_mem_req, a_mem_we, a_mem_be, a_mem_addr, a_mem_wdata);
        end
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (a_done || a_mem_req) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (a_done || a_mem_req) seen = 1'b1;
        end
        i_mem_ack = 1'b0;
        checks++;
        if (seen !== 1'b0 || a_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_abort: activity_seen=%b ready=%b, required 0 1", seen, a_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; i_valid = 1'b0; i_we = 1'b0; i_funct3 = '0;
        i_addr = '0; i_wdata = '0; i_mem_ack = 1'b0; i_mem_rdata = '0; sel = 1'b0;
        #12;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_aligned;
        test_split_load;
        test_split_store;
        test_sign;
        test_errors;
        test_clk_en;
        test_back_to_back;
        test_random;
        test_reset_mid_access;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
